// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner: FSM state codes,
// matrix geometry and the row-drive decode.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DEB_PRESS = 3'd1;
  localparam logic [2:0] SCAN      = 3'd2;
  localparam logic [2:0] HOLD      = 3'd3;
  localparam logic [2:0] DEB_REL   = 3'd4;

  // Active-low one-hot row select.
  function automatic logic [3:0] row_drive(input logic [1:0] row_idx);
    return ~(4'b0001 << row_idx);
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-tick divider: flag_tick pulses once every CNT_MAX+1 sys_clk cycles.
// Shared with the seven-segment display driver.
module keypad_tick_gen #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic flag_tick
);

  logic [15:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 16'd0;
    end else if (cnt == CNT_MAX) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign flag_tick = (cnt == CNT_MAX - 16'd1);

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad reader: synchronise, debounce, scan, emit key code.
// Define KEY_REPEAT_EN to enable auto-repeat of key_valid while a key is held.
//
// state     | meaning
// IDLE      | all rows driven low, waiting for any column to drop
// DEB_PRESS | some column low, counting stable ticks before scanning
// SCAN      | walking one driven row per tick to locate the key
// HOLD      | key located, row held, waiting for release
// DEB_REL   | all columns high, counting stable ticks before accepting release
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter logic [15:0] CNT_MAX        = 16'd49_999,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd20
`ifdef KEY_REPEAT_EN
  ,
  parameter logic [9:0]  REPEAT_DELAY   = 10'd500,
  parameter logic [9:0]  REPEAT_RATE    = 10'd100
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam logic [7:0] DEB_LAST = DEBOUNCE_TICKS - 8'd1;

  logic       flag_tick;
  logic [3:0] col_meta;
  logic [3:0] col_s;
  logic [2:0] state;
  logic [7:0] deb_cnt;
  logic [7:0] deb_next;
  logic [1:0] row_idx;
  logic [3:0] col_low;
  logic       one_low;
  logic [1:0] col_idx;

  keypad_tick_gen #(.CNT_MAX(CNT_MAX)) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flag_tick (flag_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_meta <= COL_IDLE;
      col_s    <= COL_IDLE;
    end else begin
      col_meta <= key_col;
      col_s    <= col_meta;
    end
  end

  assign col_low  = ~col_s;
  assign one_low  = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);
  assign deb_next = (deb_cnt == 8'hFF) ? deb_cnt : deb_cnt + 8'd1;

  always_comb begin
    col_idx = 2'd0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_low[c]) col_idx = 2'(c);
    end
  end

`ifdef KEY_REPEAT_EN
  logic       multi;
  logic       rep_first;
  logic [9:0] rep_cnt;
  logic [9:0] rep_limit;

  assign rep_limit = rep_first ? REPEAT_DELAY : REPEAT_RATE;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      key_row     <= 4'b0000;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      deb_cnt     <= 8'd0;
      row_idx     <= 2'd0;
`ifdef KEY_REPEAT_EN
      multi       <= 1'b0;
      rep_first   <= 1'b1;
      rep_cnt     <= 10'd0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (flag_tick) begin
        case (state)
          IDLE: begin
            if (col_s != COL_IDLE) begin
              state   <= DEB_PRESS;
              deb_cnt <= 8'd0;
            end
          end
          DEB_PRESS: begin
            if (col_s == COL_IDLE) begin
              state <= IDLE;
            end else if (deb_cnt == DEB_LAST) begin
              state   <= SCAN;
              row_idx <= 2'd0;
              key_row <= row_drive(2'd0);
            end else begin
              deb_cnt <= deb_next;
            end
          end
          SCAN: begin
            if (one_low) begin
              key_code    <= {row_idx, col_idx};
              key_valid   <= 1'b1;
              key_pressed <= 1'b1;
              state       <= HOLD;
            end else if (col_s != COL_IDLE) begin
              // Ambiguous chord: park in HOLD until release, report nothing.
`ifdef KEY_REPEAT_EN
              multi <= 1'b1;
`endif
              state <= HOLD;
            end else if (row_idx != 2'(NUM_ROWS - 1)) begin
              row_idx <= row_idx + 2'd1;
              key_row <= row_drive(row_idx + 2'd1);
            end else begin
              state   <= IDLE;
              key_row <= 4'b0000;
            end
          end
          HOLD: begin
            if (col_s == COL_IDLE) begin
              state   <= DEB_REL;
              deb_cnt <= 8'd0;
`ifdef KEY_REPEAT_EN
              rep_cnt   <= 10'd0;
              rep_first <= 1'b1;
            end else if (!multi) begin
              if (rep_cnt + 10'd1 == rep_limit) begin
                key_valid <= 1'b1;
                rep_cnt   <= 10'd0;
                rep_first <= 1'b0;
              end else begin
                rep_cnt <= rep_cnt + 10'd1;
              end
`endif
            end
          end
          DEB_REL: begin
            if (col_s != COL_IDLE) begin
              state <= HOLD;
            end else if (deb_cnt == DEB_LAST) begin
              state       <= IDLE;
              key_pressed <= 1'b0;
              key_row     <= 4'b0000;
`ifdef KEY_REPEAT_EN
              multi       <= 1'b0;
`endif
            end else begin
              deb_cnt <= deb_next;
            end
          end
          default: begin
            state   <= IDLE;
            key_row <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Self-checking bench for keypad_matrix_scan: keypad matrix emulation,
// tick-level behavioural model with per-cycle compare, and directed scenarios.
module tb_keypad_matrix_scan;

  localparam int CNT_MAX_TB = 9;
  localparam int DEB_TB     = 3;
  localparam int REP_DELAY  = 5;
  localparam int REP_RATE   = 2;
  localparam int TICK_CLKS  = CNT_MAX_TB + 1;

  localparam int P_IDLE = 0, P_DEB_PRESS = 1, P_SCAN = 2, P_HOLD = 3, P_DEB_REL = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys_down;
  bit          started;
  int          vec_cnt;
  int          err_cnt;
  int          dut_vcnt;
  int          m_vcnt;
  int          vtimes[$];

  keypad_matrix_scan #(
    .CNT_MAX        (16'd9),
    .DEBOUNCE_TICKS (8'd3)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY   (10'd5),
    .REPEAT_RATE    (10'd2)
`endif
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_col     (key_col),
    .key_row     (key_row),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // A column reads low when a pressed key sits on a row that is driven low.
  always_comb begin
    key_col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && key_row[r] == 1'b0) key_col[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      if (err_cnt <= 40) $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model, updated at each rising edge from pre-edge inputs.
  int         m_edges, m_phase, m_deb, m_row, m_rep, nlow;
  bit         m_rep_first, m_multi, tick;
  logic [3:0] m_s1, m_s2, cs;
  logic [3:0] m_key_row, m_code;
  logic       m_valid, m_pressed;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_edges = 0; m_s1 = 4'hF; m_s2 = 4'hF;
      m_phase = P_IDLE; m_deb = 0; m_row = 0; m_rep = 0; m_rep_first = 1; m_multi = 0;
      m_key_row = 4'b0000; m_code = 4'd0; m_valid = 1'b0; m_pressed = 1'b0;
    end else begin
      cs = m_s2; m_s2 = m_s1; m_s1 = key_col;
      tick = (m_edges % TICK_CLKS) == CNT_MAX_TB - 1;
      m_edges++;
      m_valid = 1'b0;
      if (tick) begin
        nlow = 4 - $countones(cs);
        case (m_phase)
          P_IDLE: if (nlow > 0) begin m_phase = P_DEB_PRESS; m_deb = 0; end
          P_DEB_PRESS: begin
            if (nlow == 0) m_phase = P_IDLE;
            else if (m_deb == DEB_TB - 1) begin m_phase = P_SCAN; m_row = 0; m_key_row = 4'b1110; end
            else m_deb++;
          end
          P_SCAN: begin
            if (nlow == 1) begin
              for (int c = 0; c < 4; c++) if (!cs[c]) m_code = 4'(m_row*4 + c);
              m_valid = 1'b1; m_vcnt++; m_pressed = 1'b1; m_multi = 0; m_phase = P_HOLD;
            end else if (nlow > 1) begin
              m_multi = 1; m_phase = P_HOLD;
            end else if (m_row < 3) begin
              m_row++; m_key_row = 4'b1111 ^ (4'b0001 << m_row);
            end else begin
              m_phase = P_IDLE; m_key_row = 4'b0000;
            end
          end
          P_HOLD: begin
            if (nlow == 0) begin
              m_phase = P_DEB_REL; m_deb = 0; m_rep = 0; m_rep_first = 1;
            end
`ifdef KEY_REPEAT_EN
            else if (!m_multi) begin
              m_rep++;
              if (m_rep == (m_rep_first ? REP_DELAY : REP_RATE)) begin
                m_valid = 1'b1; m_vcnt++; m_rep = 0; m_rep_first = 0;
              end
            end
`endif
          end
          P_DEB_REL: begin
            if (nlow > 0) m_phase = P_HOLD;
            else if (m_deb == DEB_TB - 1) begin
              m_phase = P_IDLE; m_pressed = 1'b0; m_multi = 0; m_key_row = 4'b0000;
            end else m_deb++;
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("cyc_key_row", key_row, m_key_row);
      chk("cyc_key_code", key_code, m_code);
      chk("cyc_key_valid", key_valid, m_valid);
      chk("cyc_key_pressed", key_pressed, m_pressed);
    end
    if (key_valid === 1'b1) begin
      dut_vcnt++;
      vtimes.push_back(m_edges);
    end
  end

  task automatic ticks(input int n);
    repeat (n * TICK_CLKS) @(negedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row"}, key_row, 4'b0000);
    chk({tag, "_code"}, key_code, 4'd0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_pressed"}, key_pressed, 1'b0);
  endtask

  int mark_d, mark_m;

  initial begin
    keys_down = 16'h0000;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    started = 1'b1;
    chk_reset_outputs("reset");

    // Idle for 50 ticks after reset release
    sys_rst_n = 1'b1;
    mark_d = dut_vcnt;
    ticks(50);
    chk("idle_valid_count", dut_vcnt - mark_d, 0);
    chk("idle_key_row", key_row, 4'b0000);

    // Clean press of row 2 / col 1
    mark_d = dut_vcnt; mark_m = m_vcnt;
    keys_down = 16'h1 << 9;
    ticks(9);
    chk("press9_pressed", key_pressed, 1'b1);
    chk("press9_code", key_code, 4'd9);
    ticks(1);
    keys_down = 16'h0;
    ticks(8);
    chk("press9_valid_count", dut_vcnt - mark_d, 1);
    chk("press9_model_count", m_vcnt - mark_m, 1);
    chk("press9_released", key_pressed, 1'b0);
    chk("press9_code_kept", key_code, 4'd9);
    chk("press9_row_idle", key_row, 4'b0000);

    // Bounce on key 0, then a one-tick release glitch while held
    mark_d = dut_vcnt;
    keys_down = 16'h1; ticks(1);
    keys_down = 16'h0; ticks(1);
    chk("bounce_no_valid", dut_vcnt - mark_d, 0);
    keys_down = 16'h1; ticks(6);
    keys_down = 16'h0; ticks(1);
    keys_down = 16'h1; ticks(4);
    keys_down = 16'h0; ticks(8);
    chk("bounce_valid_count", dut_vcnt - mark_d, 1);
    chk("bounce_code", key_code, 4'd0);

    // Two columns on row 1, then a fresh press of key 15
    mark_d = dut_vcnt;
    keys_down = (16'h1 << 4) | (16'h1 << 7);
    ticks(8);
    chk("multi_pressed", key_pressed, 1'b0);
    keys_down = 16'h0;
    ticks(8);
    chk("multi_no_valid", dut_vcnt - mark_d, 0);
    keys_down = 16'h1 << 15;
    ticks(10);
    keys_down = 16'h0;
    ticks(8);
    chk("key15_valid_count", dut_vcnt - mark_d, 1);
    chk("key15_code", key_code, 4'd15);

    // Single-tick glitch
    mark_d = dut_vcnt;
    keys_down = 16'h1 << 5; ticks(1);
    keys_down = 16'h0; ticks(6);
    chk("glitch_no_valid", dut_vcnt - mark_d, 0);
    chk("glitch_code_kept", key_code, 4'd15);
    chk("glitch_row_idle", key_row, 4'b0000);

    // Long hold of key 5
    mark_m = m_vcnt;
    vtimes.delete();
    keys_down = 16'h1 << 5;
    ticks(17);
    keys_down = 16'h0;
    ticks(8);
    chk("hold5_code", key_code, 4'd5);
`ifdef KEY_REPEAT_EN
    chk("hold5_valid_count", vtimes.size(), 5);
    chk("hold5_model_count", m_vcnt - mark_m, 5);
    for (int i = 1; i < 5; i++) begin
      if (i < vtimes.size())
        chk($sformatf("hold5_gap%0d", i), vtimes[i] - vtimes[i-1], (i == 1) ? 50 : 20);
    end
`else
    chk("hold5_valid_count", vtimes.size(), 1);
    chk("hold5_model_count", m_vcnt - mark_m, 1);
`endif

    // Reset in the middle of a press
    mark_d = dut_vcnt;
    keys_down = 16'h1 << 9;
    ticks(5);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge sys_clk);
    keys_down = 16'h0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ticks(15);
    chk("midreset_no_valid", dut_vcnt - mark_d, 0);
    chk("midreset_code", key_code, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
